// File: rtl/fixed_point_iterative_accumulator_if.sv
// Val/rdy bundle between a product source, the accumulator and the sum consumer.
// master = source/consumer side, slave = accumulator side.
interface fixed_point_iterative_accumulator_if #(
    parameter int n = 32
);
    logic         recv_val;
    logic         recv_rdy;
    logic [n-1:0] a;
    logic         send_val;
    logic         send_rdy;
    logic [n-1:0] c;
    logic         sat;

    modport master (
        output recv_val, a, send_rdy,
        input  recv_rdy, send_val, c, sat
    );

    modport slave (
        input  recv_val, a, send_rdy,
        output recv_rdy, send_val, c, sat
    );
endinterface

// File: rtl/fixed_point_iterative_accumulator.sv
// Sums exactly len fixed-point products in a guard-bit accumulator, then emits
// one saturated n-bit sum. Two-state ACC/DONE FSM, no overlap between phases.
module fixed_point_iterative_accumulator #(
    parameter int n    = 32,
    parameter int d    = 16,
    parameter bit sign = 1'b1,
    parameter int len  = 8
) (
    input  logic clk,
    input  logic reset,
    fixed_point_iterative_accumulator_if.slave bus
);
    localparam int W  = n + $clog2(len);
    localparam int CW = $clog2(len) + 1;
    localparam int G  = W - n;
    localparam logic [CW-1:0] LAST_COUNT = CW'(len - 1);

    // Reject illegal configurations at elaboration instead of producing a wrong sum.
    if (len < 2 || len > 256) begin : g_bad_len
        $error("fixed_point_iterative_accumulator: len must be in 2..256");
    end
    if (d < 0 || d > n) begin : g_bad_d
        $error("fixed_point_iterative_accumulator: d must be in 0..n");
    end

    typedef enum logic [1:0] {
        ACC  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t        state;
    logic [W-1:0]  acc;
    logic [CW-1:0] count;
    logic          rdy_q;
    logic          val_q;

    logic [W-1:0]  a_ext;
    logic          accept;
    logic          last;
    logic [G:0]    top;
    logic [n-1:0]  c_sat;
    logic          sat_flag;

    assign a_ext = sign ? {{G{bus.a[n-1]}}, bus.a} : {{G{1'b0}}, bus.a};

    // Handshake flags are registered but gated by reset so they drop the
    // moment reset asserts, without waiting for a clock.
    assign bus.recv_rdy = reset & rdy_q;
    assign bus.send_val = reset & val_q;

    assign accept = bus.recv_val & bus.recv_rdy;
    assign last   = (count == LAST_COUNT);

    // NOTE: state is written with <= only, so every register samples the
    // pre-edge values and the order of statements inside the block is irrelevant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ACC;
            acc   <= '0;
            count <= '0;
            rdy_q <= 1'b1;
            val_q <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        acc   <= acc + a_ext;
                        count <= count + 1'b1;
                        if (last) begin
                            state <= DONE;
                            rdy_q <= 1'b0;
                            val_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.send_rdy) begin
                        state <= ACC;
                        acc   <= '0;
                        count <= '0;
                        rdy_q <= 1'b1;
                        val_q <= 1'b0;
                    end
                end
                default: begin
                    state <= ACC;
                    acc   <= '0;
                    count <= '0;
                    rdy_q <= 1'b1;
                    val_q <= 1'b0;
                end
            endcase
        end
    end

    // Signed result fits in n bits iff the guard bits and the n-bit sign bit agree.
    assign top = acc[W-1:n-1];

    // NOTE: both outputs get a default before any branch so no path leaves them
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        c_sat    = acc[n-1:0];
        sat_flag = 1'b0;
        if (sign) begin
            if (!(&top) && (|top)) begin
                sat_flag = 1'b1;
                c_sat    = acc[W-1] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
            end
        end else if (|acc[W-1:n]) begin
            sat_flag = 1'b1;
            c_sat    = '1;
        end
    end

    assign bus.c   = c_sat;
    assign bus.sat = sat_flag;

endmodule

// File: tb/tb_fixed_point_iterative_accumulator.sv
// Directed bench: one signed and one unsigned accumulator (len=4), vector table
// plus hand-written backpressure and async-reset sequences.
module tb_fixed_point_iterative_accumulator;
    logic clk;
    logic reset;

    fixed_point_iterative_accumulator_if #(.n(32)) s_if ();
    fixed_point_iterative_accumulator_if #(.n(32)) u_if ();

    fixed_point_iterative_accumulator #(.n(32), .d(16), .sign(1'b1), .len(4)) u_dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (s_if)
    );

    fixed_point_iterative_accumulator #(.n(32), .d(16), .sign(1'b0), .len(4)) u_dut_u (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string             name;
        bit                uns;
        logic [3:0][31:0]  a;
        int                gap;
        logic [31:0]       exp_c;
        logic              exp_sat;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(input string name, input bit uns,
                                input logic [31:0] a0, a1, a2, a3,
                                input int gap, input logic [31:0] exp_c,
                                input logic exp_sat);
        vec_t v;
        v.name    = name;
        v.uns     = uns;
        v.a[0]    = a0;
        v.a[1]    = a1;
        v.a[2]    = a2;
        v.a[3]    = a3;
        v.gap     = gap;
        v.exp_c   = exp_c;
        v.exp_sat = exp_sat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input bit uns, input logic v, input logic [31:0] a);
        if (uns) begin
            u_if.recv_val = v;
            u_if.a        = a;
        end else begin
            s_if.recv_val = v;
            s_if.a        = a;
        end
    endtask

    task automatic set_send_rdy(input bit uns, input logic v);
        if (uns) u_if.send_rdy = v;
        else     s_if.send_rdy = v;
    endtask

    task automatic sample(input bit uns, output logic rr, output logic sv,
                          output logic [31:0] c, output logic sat);
        if (uns) begin
            rr = u_if.recv_rdy; sv = u_if.send_val; c = u_if.c; sat = u_if.sat;
        end else begin
            rr = s_if.recv_rdy; sv = s_if.send_val; c = s_if.c; sat = s_if.sat;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one product for exactly one edge, then idles for gap cycles.
    task automatic feed(input string tag, input bit uns, input logic [31:0] a, input int gap);
        logic rr, sv, sat;
        logic [31:0] c;
        drive(uns, 1'b1, a);
        sample(uns, rr, sv, c, sat);
        check({tag, "_rdy_before_accept"}, {31'b0, rr}, 32'd1);
        step();
        drive(uns, 1'b0, 32'h0);
        repeat (gap) step();
    endtask

    // Pulls the sum out and checks the block is back in ACC with a cleared sum.
    task automatic transfer(input string tag, input bit uns);
        logic rr, sv, sat;
        logic [31:0] c;
        set_send_rdy(uns, 1'b1);
        step();
        set_send_rdy(uns, 1'b0);
        sample(uns, rr, sv, c, sat);
        check({tag, "_rdy_after_xfer"}, {31'b0, rr}, 32'd1);
        check({tag, "_val_after_xfer"}, {31'b0, sv}, 32'd0);
        check({tag, "_c_cleared"},      c,           32'h0);
    endtask

    task automatic run_vec(input vec_t v);
        logic rr, sv, sat;
        logic [31:0] c;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                sample(v.uns, rr, sv, c, sat);
                check({v.name, "_val_before_last"}, {31'b0, sv}, 32'd0);
            end
            feed(v.name, v.uns, v.a[i], (i == 3) ? 0 : v.gap);
        end
        sample(v.uns, rr, sv, c, sat);
        check({v.name, "_send_val"}, {31'b0, sv},  32'd1);
        check({v.name, "_c"},        c,            v.exp_c);
        check({v.name, "_sat"},      {31'b0, sat}, {31'b0, v.exp_sat});
        check({v.name, "_rdy_done"}, {31'b0, rr},  32'd0);
        transfer(v.name, v.uns);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rr, sv, sat;
        logic [31:0] c;
        logic [31:0] held_c;

        vecs[0]  = mk("basic",      1'b0, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 0, 32'h00040000, 1'b0);
        vecs[1]  = mk("mixed_gaps", 1'b0, 32'h00018000, 32'hFFFF0000, 32'h00004000, 32'hFFFFC000, 2, 32'h00008000, 1'b0);
        vecs[2]  = mk("pos_sat",    1'b0, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 0, 32'h7FFFFFFF, 1'b1);
        vecs[3]  = mk("neg_sat",    1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 0, 32'h80000000, 1'b1);
        vecs[4]  = mk("overshoot",  1'b0, 32'h7FFF0000, 32'h7FFF0000, 32'h80010000, 32'h80010000, 0, 32'h00000000, 1'b0);
        vecs[5]  = mk("max_exact",  1'b0, 32'h7FFFFFFF, 32'h0,        32'h0,        32'h0,        1, 32'h7FFFFFFF, 1'b0);
        vecs[6]  = mk("max_plus1",  1'b0, 32'h7FFFFFFF, 32'h1,        32'h0,        32'h0,        0, 32'h7FFFFFFF, 1'b1);
        vecs[7]  = mk("min_exact",  1'b0, 32'h80000000, 32'h0,        32'h0,        32'h0,        0, 32'h80000000, 1'b0);
        vecs[8]  = mk("min_minus1", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h0,        0, 32'h80000000, 1'b1);
        vecs[9]  = mk("u_sat",      1'b1, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 0, 32'hFFFFFFFF, 1'b1);
        vecs[10] = mk("u_small",    1'b1, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001, 1, 32'h00000004, 1'b0);
        vecs[11] = mk("u_max_exact",1'b1, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        0, 32'hFFFFFFFF, 1'b0);
        vecs[12] = mk("u_max_plus1",1'b1, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,        0, 32'hFFFFFFFF, 1'b1);

        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h0);
        set_send_rdy(1'b0, 1'b0);
        set_send_rdy(1'b1, 1'b0);

        #12;
        for (int k = 0; k < 2; k++) begin
            sample(k[0], rr, sv, c, sat);
            check($sformatf("reset_rdy_%0d", k), {31'b0, rr}, 32'd0);
            check($sformatf("reset_val_%0d", k), {31'b0, sv}, 32'd0);
        end
        step();
        reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            sample(k[0], rr, sv, c, sat);
            check($sformatf("post_reset_rdy_%0d", k), {31'b0, rr},  32'd1);
            check($sformatf("post_reset_val_%0d", k), {31'b0, sv},  32'd0);
            check($sformatf("post_reset_c_%0d", k),   c,            32'h0);
            check($sformatf("post_reset_sat_%0d", k), {31'b0, sat}, 32'd0);
        end
        step();

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Backpressure: sum held in DONE while upstream keeps offering data.
        for (int i = 0; i < 4; i++) feed("bp", 1'b0, 32'h00010000, 0);
        sample(1'b0, rr, sv, held_c, sat);
        check("bp_c_initial", held_c, 32'h00040000);
        drive(1'b0, 1'b1, 32'h00010000);
        for (int i = 0; i < 10; i++) begin
            step();
            sample(1'b0, rr, sv, c, sat);
            check($sformatf("bp_hold_c_%0d", i),   c,           held_c);
            check($sformatf("bp_hold_rdy_%0d", i), {31'b0, rr}, 32'd0);
            check($sformatf("bp_hold_val_%0d", i), {31'b0, sv}, 32'd1);
        end
        drive(1'b0, 1'b0, 32'h0);
        transfer("bp", 1'b0);
        run_vec(mk("bp_next_2p0", 1'b0, 32'h00020000, 32'h00020000, 32'h00020000, 32'h00020000,
                   0, 32'h00080000, 1'b0));

        // Async reset after two accepts, asserted between clock edges.
        feed("rst", 1'b0, 32'h00010000, 0);
        feed("rst", 1'b0, 32'h00010000, 0);
        #2;
        reset = 1'b0;
        #1;
        sample(1'b0, rr, sv, c, sat);
        check("rst_mid_rdy", {31'b0, rr}, 32'd0);
        check("rst_mid_val", {31'b0, sv}, 32'd0);
        check("rst_mid_c",   c,           32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        sample(1'b0, rr, sv, c, sat);
        check("rst_release_rdy", {31'b0, rr}, 32'd1);
        step();
        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
